if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined CPU.
- Owns the fetch PC and drives a req/ready instruction-memory port.
- Presents {PC, instruction, valid} to the IF/ID pipeline register.
- Honours downstream stall (IF/ID enable low) and redirect/flush from branch resolution, including discarding an in-flight fetch after a redirect.

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 tb/tb_if_fetch_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// instruction width, PC increment and the default bubble instruction.
package if_fetch_stage_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'b00,
        FETCH_BUSY  = 2'b01,
        FETCH_DRAIN = 2'b10
    } fetch_state_e;

    // Word-align a redirect target; the low two bits are never meaningful.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding
// request at a time to instruction memory and presents the fetched word
// in a single-entry IF/ID slot. Redirects flush the slot and, if a fetch
// is still in flight, its response is drained and thrown away.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0]       RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk_IF,
    input  logic              rst_IF,
    input  logic              stall_IF,
    input  logic              redirect_IF,
    input  logic [31:0]       redirect_PC_IF,
    output logic              imem_req_IF,
    output logic [31:0]       imem_addr_IF,
    input  logic              imem_ready_IF,
    input  logic [INST_W-1:0] imem_data_IF,
    output logic [31:0]       PC_out_IF,
    output logic [INST_W-1:0] inst_out_IF,
    output logic              valid_out_IF
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       tgt_q, tgt_d;
    logic [31:0]       pcOut_q, pcOut_d;
    logic [INST_W-1:0] instOut_q, instOut_d;
    logic              validOut_q, validOut_d;

    logic        consume;
    logic        slotFree;
    logic        reqInt;
    logic        acceptNow;
    logic [31:0] redirectTarget;

    // Slot handshake and request generation; a request is only started
    // from IDLE when the slot will have room for the answer.
    always_comb begin
        consume        = validOut_q & ~stall_IF;
        slotFree       = ~validOut_q | consume;
        reqInt         = ((state_q == FETCH_IDLE) & slotFree & ~redirect_IF)
                       | (state_q == FETCH_BUSY)
                       | (state_q == FETCH_DRAIN);
        acceptNow      = ~redirect_IF & imem_ready_IF
                       & (((state_q == FETCH_IDLE) & slotFree) | (state_q == FETCH_BUSY));
        redirectTarget = alignPc(redirect_PC_IF);
    end

    // Reset must kill the request immediately, not at the next edge.
    always_comb begin
        imem_req_IF  = reqInt & ~rst_IF;
        imem_addr_IF = pc_q;
    end

    // Next-state: redirect beats accept, accept beats a plain consume.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        pcOut_d    = pcOut_q;
        instOut_d  = instOut_q;
        validOut_d = validOut_q;

        if (redirect_IF) begin
            validOut_d = 1'b0;
            instOut_d  = NOP_INST;
            if (state_q == FETCH_IDLE) begin
                pc_d = redirectTarget;
            end else if (imem_ready_IF) begin
                pc_d    = redirectTarget;
                state_d = FETCH_IDLE;
            end else begin
                tgt_d   = redirectTarget;
                state_d = FETCH_DRAIN;
            end
        end else if (acceptNow) begin
            pcOut_d    = pc_q;
            instOut_d  = imem_data_IF;
            validOut_d = 1'b1;
            pc_d       = pc_q + PC_INC;
            state_d    = FETCH_IDLE;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (reqInt) begin
                        state_d = FETCH_BUSY;
                    end
                end
                FETCH_BUSY: begin
                    state_d = FETCH_BUSY;
                end
                FETCH_DRAIN: begin
                    if (imem_ready_IF) begin
                        pc_d    = tgt_q;
                        state_d = FETCH_IDLE;
                    end
                end
                default: begin
                    state_d = FETCH_IDLE;
                end
            endcase
            if (consume) begin
                validOut_d = 1'b0;
            end
        end
    end

    // All stage state, including the presented slot, lives in one register bank.
    always_ff @(posedge clk_IF or posedge rst_IF) begin
        if (rst_IF) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            tgt_q      <= 32'h0000_0000;
            pcOut_q    <= 32'h0000_0000;
            instOut_q  <= NOP_INST;
            validOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            pcOut_q    <= pcOut_d;
            instOut_q  <= instOut_d;
            validOut_q <= validOut_d;
        end
    end

    assign PC_out_IF    = pcOut_q;
    assign inst_out_IF  = instOut_q;
    assign valid_out_IF = validOut_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for the fetch stage: directed scenarios followed by random
// stall/redirect/memory-latency traffic, compared every cycle against a
// transaction-level model of the fetch stream.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] data;
    logic [31:0] pcOut;
    logic [31:0] instOut;
    logic        validOut;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: next PC to fetch, whether a fetch is in flight,
    // whether its answer is unwanted (and where to go afterwards), and
    // the contents of the presented slot.
    logic [31:0] mPc;
    logic        mInFlight;
    logic        mDiscard;
    logic [31:0] mAfterDrain;
    logic        mValid;
    logic [31:0] mPcOut;
    logic [31:0] mInst;

    if_fetch_stage #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk_IF        (clk),
        .rst_IF        (rst),
        .stall_IF      (stall),
        .redirect_IF   (redirect),
        .redirect_PC_IF(redirectPc),
        .imem_req_IF   (req),
        .imem_addr_IF  (addr),
        .imem_ready_IF (ready),
        .imem_data_IF  (data),
        .PC_out_IF     (pcOut),
        .inst_out_IF   (instOut),
        .valid_out_IF  (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] dataFor(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPc         = RESET_PC;
        mInFlight   = 1'b0;
        mDiscard    = 1'b0;
        mAfterDrain = 32'h0;
        mValid      = 1'b0;
        mPcOut      = 32'h0;
        mInst       = NOP_INST;
    endtask

    // One clock cycle: called in the low phase, returns at the next negedge.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] tgt, input logic rdyWant);
        logic        expReq;
        logic        consume;
        logic [31:0] tgtAligned;
        stall      = st;
        redirect   = rd;
        redirectPc = tgt;
        expReq     = mInFlight || ((!mValid || !st) && !rd);
        ready      = expReq && rdyWant;
        #1;
        data = dataFor(addr);
        #1;
        checkOutput("imem_req", {31'b0, req}, {31'b0, expReq});
        if (expReq) checkOutput("imem_addr", addr, mPc);
        @(posedge clk);
        tgtAligned = tgt & ~32'h3;
        consume    = mValid && !st;
        if (rd) begin
            mValid = 1'b0;
            mInst  = NOP_INST;
            if (mInFlight && !ready) begin
                mDiscard    = 1'b1;
                mAfterDrain = tgtAligned;
            end else begin
                mPc       = tgtAligned;
                mInFlight = 1'b0;
                mDiscard  = 1'b0;
            end
        end else if (expReq && ready) begin
            if (mDiscard) begin
                mPc = mAfterDrain;
            end else begin
                mPcOut = mPc;
                mInst  = dataFor(mPc);
                mValid = 1'b1;
                mPc    = mPc + 32'd4;
            end
            mInFlight = 1'b0;
            mDiscard  = 1'b0;
        end else begin
            if (expReq) mInFlight = 1'b1;
            if (consume) mValid = 1'b0;
        end
        #1;
        checkOutput("valid_out", {31'b0, validOut}, {31'b0, mValid});
        checkOutput("PC_out", pcOut, mPcOut);
        checkOutput("inst_out", instOut, mInst);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        ready      = 1'b0;
        data       = 32'h0;
        modelReset();
        @(negedge clk);
        #1;
        checkOutput("reset_req", {31'b0, req}, 32'h0);
        checkOutput("reset_valid", {31'b0, validOut}, 32'h0);
        checkOutput("reset_pc_out", pcOut, 32'h0);
        checkOutput("reset_inst", instOut, NOP_INST);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait streaming from reset
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Three wait cycles on one fetch, then the answer
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Stall with a full slot, then release
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Redirect while busy, second redirect while draining
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Redirect in the same cycle as the answer, unaligned target
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h43, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a busy fetch
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst   = 1'b1;
        ready = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_req", {31'b0, req}, 32'h0);
        checkOutput("async_rst_valid", {31'b0, validOut}, 32'h0);
        checkOutput("async_rst_inst", instOut, NOP_INST);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_pc_out", pcOut, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 9) == 0),
                          $urandom,
                          ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
